// File: rtl/fpu_pkg.sv
// Shared types for the FPU completion path: result entry layout and depth legality check.
// Latency: n/a (types only).
// Backpressure: n/a.
package fpu_pkg;

    localparam int LG_PRF_WIDTH = 4;
    localparam int LG_ROB_WIDTH = 4;
    localparam int LG_FCR_WIDTH = 4;

    typedef struct packed {
        logic [63:0]             y;
        logic [LG_ROB_WIDTH-1:0] rob;
        logic [LG_PRF_WIDTH-1:0] dst;
        logic [LG_FCR_WIDTH-1:0] fcr;
        logic                    is_cmp;
    } fpu_result_t;

    // The FPU cannot stall, so the buffer must absorb a full pipe of results plus one.
    function automatic bit depth_legal(input int lg_depth, input int fpu_lat);
        return (1 << lg_depth) >= (fpu_lat + 1);
    endfunction

endpackage

// File: rtl/fpu_complete_if.sv
// FPU result capture, completion port and issue-credit signals of fpu_complete.
// Latency: n/a (wires only).
// Backpressure: out_valid/out_ready on the completion side; can_issue toward the scheduler.
interface fpu_complete_if
    import fpu_pkg::*;
#(
    parameter int LG_DEPTH = 2
);
    logic                    fpu_start;
    logic                    in_val;
    logic                    in_cmp_val;
    logic [63:0]             in_y;
    logic [LG_ROB_WIDTH-1:0] in_rob_ptr;
    logic [LG_PRF_WIDTH-1:0] in_dst_ptr;
    logic [LG_FCR_WIDTH-1:0] in_fcr_ptr;
    logic                    out_valid;
    logic                    out_ready;
    logic [63:0]             out_y;
    logic [LG_ROB_WIDTH-1:0] out_rob_ptr;
    logic [LG_PRF_WIDTH-1:0] out_dst_ptr;
    logic [LG_FCR_WIDTH-1:0] out_fcr_ptr;
    logic                    out_is_cmp;
    logic                    can_issue;
    logic [LG_DEPTH:0]       occupancy;
    logic                    err;

    modport master (
        output fpu_start, in_val, in_cmp_val, in_y, in_rob_ptr, in_dst_ptr, in_fcr_ptr, out_ready,
        input  out_valid, out_y, out_rob_ptr, out_dst_ptr, out_fcr_ptr, out_is_cmp,
               can_issue, occupancy, err
    );

    modport slave (
        input  fpu_start, in_val, in_cmp_val, in_y, in_rob_ptr, in_dst_ptr, in_fcr_ptr, out_ready,
        output out_valid, out_y, out_rob_ptr, out_dst_ptr, out_fcr_ptr, out_is_cmp,
               can_issue, occupancy, err
    );
endinterface

// File: rtl/fpu_result_fifo.sv
// Circular FIFO of fpu_result_t with registered head, occupancy and full/empty.
// Latency: 1 cycle write-to-head.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module fpu_result_fifo
    import fpu_pkg::*;
#(
    parameter int LG_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  fpu_result_t       wdata_i,
    output fpu_result_t       head_o,
    output logic [LG_DEPTH:0] occupancy_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int DEPTH = 1 << LG_DEPTH;

    fpu_result_t           mem_q [DEPTH];
    logic [LG_DEPTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LG_DEPTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LG_DEPTH:0]     occ_q, occ_d;
    logic                  wr_en, rd_en;

    assign full_o      = (occ_q == (LG_DEPTH+1)'(DEPTH));
    assign empty_o     = (occ_q == '0);
    assign occupancy_o = occ_q;
    assign head_o      = mem_q[rd_ptr_q];

    assign wr_en = push_i & (~full_o | pop_i);
    assign rd_en = pop_i & ~empty_o;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + LG_DEPTH'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + LG_DEPTH'(1);
        if (wr_en && !rd_en)      occ_d = occ_q + (LG_DEPTH+1)'(1);
        else if (!wr_en && rd_en) occ_d = occ_q - (LG_DEPTH+1)'(1);
    end

    // Storage is reset so the completion outputs read zero out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
        end
    end
endmodule

// File: rtl/fpu_complete.sv
// FPU completion buffer with in-flight credit to the scheduler; FPU_COMPLETE_BYPASS_EN adds an empty-FIFO bypass.
// Latency: 1 cycle push-to-out_valid (0 cycles through the bypass when enabled and empty).
// Backpressure: out_valid/out_ready downstream; upstream throttled only via can_issue.
module fpu_complete
    import fpu_pkg::*;
#(
    parameter int FPU_LAT  = 2,
    parameter int LG_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    fpu_complete_if.slave bus
);
    localparam int DEPTH = 1 << LG_DEPTH;
    localparam logic [LG_DEPTH:0] INFL_MAX = '1;

    if (!depth_legal(LG_DEPTH, FPU_LAT)) begin : g_depth_check
        $error("fpu_complete: FIFO depth must be at least FPU_LAT+1");
    end

    fpu_result_t         in_res, head, out_res;
    logic                push, fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
    logic [LG_DEPTH:0]   fifo_occ, inflight_q, inflight_d;
    logic [LG_DEPTH+1:0] credit_sum;
    logic                err_q, err_d, can_issue;

    assign push   = bus.in_val | bus.in_cmp_val;
    assign in_res = '{y: bus.in_y, rob: bus.in_rob_ptr, dst: bus.in_dst_ptr,
                      fcr: bus.in_fcr_ptr, is_cmp: bus.in_cmp_val};

`ifdef FPU_COMPLETE_BYPASS_EN
    assign bus.out_valid = ~fifo_empty | push;
    assign out_res       = fifo_empty ? in_res : head;
    assign fifo_push     = push & ~(fifo_empty & bus.out_ready);
`else
    assign bus.out_valid = ~fifo_empty;
    assign out_res       = head;
    assign fifo_push     = push;
`endif
    assign fifo_pop = bus.out_ready & ~fifo_empty;
    assign drop     = push & fifo_full & ~fifo_pop;

    fpu_result_fifo #(.LG_DEPTH(LG_DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .pop_i       (fifo_pop),
        .wdata_i     (in_res),
        .head_o      (head),
        .occupancy_o (fifo_occ),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign bus.out_y       = out_res.y;
    assign bus.out_rob_ptr = out_res.rob;
    assign bus.out_dst_ptr = out_res.dst;
    assign bus.out_fcr_ptr = out_res.fcr;
    assign bus.out_is_cmp  = out_res.is_cmp;
    assign bus.occupancy   = fifo_occ;
    assign bus.err         = err_q;
    assign bus.can_issue   = can_issue;

    // Every issued op holds a slot until its result lands, so held + in flight never exceeds DEPTH.
    assign credit_sum = {1'b0, fifo_occ} + {1'b0, inflight_q};
    assign can_issue  = credit_sum < (LG_DEPTH+2)'(DEPTH);

    always_comb begin
        inflight_d = inflight_q;
        if (bus.fpu_start && !push) begin
            if (inflight_q != INFL_MAX) inflight_d = inflight_q + (LG_DEPTH+1)'(1);
        end else if (push && !bus.fpu_start && inflight_q != '0) begin
            inflight_d = inflight_q - (LG_DEPTH+1)'(1);
        end
    end

    assign err_d = err_q | drop | (push & (inflight_q == '0))
                 | (bus.fpu_start & ~can_issue) | (bus.in_val & bus.in_cmp_val);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_fpu_complete.sv
// Randomized scoreboard bench for fpu_complete against a transaction-level model of buffer, credit and error rules.
module tb_fpu_complete;
    import fpu_pkg::*;

    localparam int LG_DEPTH = 2;
    localparam int DEPTH    = 4;
    localparam int FPU_LAT  = 2;
`ifdef FPU_COMPLETE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        fpu_result_t res;
        int          due;
    } pend_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpu_complete_if #(.LG_DEPTH(LG_DEPTH)) bus ();

    fpu_complete #(.FPU_LAT(FPU_LAT), .LG_DEPTH(LG_DEPTH)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    fpu_result_t exp_q[$];
    pend_t       pipe_q[$];
    fpu_result_t zr = '0;
    fpu_result_t mon_got, mon_exp;
    int n_vec = 0, n_miss = 0, cyc = 0, n_done = 0;
    int m_occ = 0, m_inflight = 0;
    bit m_err = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic fpu_result_t rand_res();
        fpu_result_t r;
        r.y      = {$urandom, $urandom};
        r.rob    = LG_ROB_WIDTH'($urandom);
        r.dst    = LG_PRF_WIDTH'($urandom);
        r.fcr    = LG_FCR_WIDTH'($urandom);
        r.is_cmp = 1'($urandom);
        return r;
    endfunction

    // Completions are compared in push order whenever the port handshakes.
    initial forever begin
        @(negedge clk);
        if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            mon_got = '{y: bus.out_y, rob: bus.out_rob_ptr, dst: bus.out_dst_ptr,
                        fcr: bus.out_fcr_ptr, is_cmp: bus.out_is_cmp};
            n_done++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_completion: got %0h, expected none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                check("completion", mon_got, mon_exp);
            end
        end
    end

    // One clock cycle: drive at posedge+1, check registered state at negedge, advance the model.
    task automatic step(input bit start, input fpu_result_t sres, input bit inj_v, input bit inj_c,
                        input fpu_result_t ires, input bit ready);
        bit val, cmp, push, pop, acc, m_can;
        fpu_result_t pres, e;
        val = inj_v; cmp = inj_c; pres = ires;
        if (pipe_q.size() > 0 && pipe_q[0].due == cyc) begin
            pres = pipe_q[0].res;
            val  = !pres.is_cmp;
            cmp  = pres.is_cmp;
            void'(pipe_q.pop_front());
        end
        bus.fpu_start  = start;
        bus.in_val     = val;
        bus.in_cmp_val = cmp;
        bus.in_y       = pres.y;
        bus.in_rob_ptr = pres.rob;
        bus.in_dst_ptr = pres.dst;
        bus.in_fcr_ptr = pres.fcr;
        bus.out_ready  = ready;
        if (start) pipe_q.push_back('{res: sres, due: cyc + FPU_LAT});
        push  = val | cmp;
        m_can = (m_occ + m_inflight) < DEPTH;
        pop   = ready && (m_occ > 0 || (BYP && push));
        acc   = push && (m_occ < DEPTH || pop);
        if (acc) begin
            e = pres;
            e.is_cmp = cmp;
            exp_q.push_back(e);
        end
        @(negedge clk);
        check("can_issue", bus.can_issue, m_can);
        check("occupancy", bus.occupancy, m_occ);
        check("err", bus.err, m_err);
        check("out_valid", bus.out_valid, (m_occ > 0) || (BYP && push));
        m_err = m_err | (push && !acc) | (push && m_inflight == 0) | (start && !m_can) | (val && cmp);
        m_occ = m_occ + int'(acc) - int'(pop);
        if (start && !push) m_inflight++;
        else if (push && !start && m_inflight > 0) m_inflight--;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input bit ready);
        step(1'b0, zr, 1'b0, 1'b0, zr, ready);
    endtask

    task automatic do_reset();
        bus.fpu_start = 0; bus.in_val = 0; bus.in_cmp_val = 0; bus.out_ready = 0;
        bus.in_y = '0; bus.in_rob_ptr = '0; bus.in_dst_ptr = '0; bus.in_fcr_ptr = '0;
        rst_n = 1'b0;
        exp_q.delete();
        pipe_q.delete();
        m_occ = 0; m_inflight = 0; m_err = 1'b0;
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_occupancy", bus.occupancy, 0);
        check("rst_can_issue", bus.can_issue, 1);
        check("rst_err", bus.err, 0);
        check("rst_out_data", {bus.out_y, bus.out_rob_ptr, bus.out_dst_ptr, bus.out_fcr_ptr, bus.out_is_cmp}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        fpu_result_t r;
        int nst, issued;
        bit s, m_can;

        @(posedge clk);
        #1;
        do_reset();

        // Single DP add, then a compare writing FCR 2.
        r = '{y: 64'h4000_0000_0000_0000, rob: 4'd3, dst: 4'd5, fcr: 4'd0, is_cmp: 1'b0};
        step(1'b1, r, 1'b0, 1'b0, zr, 1'b1);
        repeat (4) idle(1'b1);
        r = '{y: 64'h05, rob: 4'd7, dst: 4'd0, fcr: 4'd2, is_cmp: 1'b1};
        step(1'b1, r, 1'b0, 1'b0, zr, 1'b1);
        repeat (4) idle(1'b1);

        // Fill with the port stalled, issuing whenever the DUT grants credit.
        nst = 0;
        for (int i = 0; i < 10; i++) begin
            s = bus.can_issue;
            if (s) nst++;
            step(s, rand_res(), 1'b0, 1'b0, zr, 1'b0);
        end
        check("fill_starts", nst, 4);
        check("fill_occupancy", bus.occupancy, 4);
        check("fill_can_issue", bus.can_issue, 0);
        check("fill_err", bus.err, 0);

        // Push into a full FIFO with no pop: dropped, err latches.
        r = rand_res(); r.is_cmp = 1'b0;
        step(1'b0, zr, 1'b1, 1'b0, r, 1'b0);
        check("drop_err", bus.err, 1);
        check("drop_occupancy", bus.occupancy, 4);

        // Push and pop together while full: occupancy holds, order preserved.
        repeat (2) begin
            r = rand_res(); r.is_cmp = 1'b0;
            step(1'b0, zr, 1'b1, 1'b0, r, 1'b1);
        end
        check("fullpp_occupancy", bus.occupancy, 4);

        // Mid-stream reset with entries held and err set.
        do_reset();

        // Both result valids at once: stored as compare, err sets.
        r = rand_res(); r.is_cmp = 1'b0;
        step(1'b1, r, 1'b0, 1'b0, zr, 1'b1);
        r = rand_res();
        step(1'b0, zr, 1'b1, 1'b1, r, 1'b1);
        check("both_err", bus.err, 1);
        repeat (4) idle(1'b1);
        do_reset();

        // 100 random results under random out_ready.
        issued = 0;
        n_done = 0;
        for (int c = 0; c < 3000 && !(issued == 100 && pipe_q.size() == 0 && exp_q.size() == 0); c++) begin
            m_can = (m_occ + m_inflight) < DEPTH;
            s = m_can && issued < 100 && ($urandom_range(3) != 0);
            if (s) issued++;
            step(s, rand_res(), 1'b0, 1'b0, zr, $urandom_range(2) != 0);
        end
        check("rand_leftover", exp_q.size() + pipe_q.size(), 0);
        check("rand_completions", n_done, 100);
        check("rand_inflight", dut.inflight_q, 0);
        check("rand_final_err", bus.err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
